// File: rtl/adc_sar_pkg.sv
// Shared types and defaults for the SAR ADC controller and the analog model wrapper.
`timescale 1ns/1ps
package adc_sar_pkg;
    localparam int ADC_SAR_N             = 12;
    localparam int ADC_SAR_SAMPLE_CYCLES = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SAMPLE = 2'd1,
        ST_CONV   = 2'd2
    } sar_state_t;

    // HI: ms_clk is high and about to fall; LO: comparator result is valid.
    typedef enum logic {
        PH_HI = 1'b0,
        PH_LO = 1'b1
    } sar_phase_t;
endpackage

// File: rtl/adc_sar_ctrl_if.sv
// Start/done handshake plus analog-macro signals of the SAR controller.
// ADC_SAR_CTRL_CONTINUOUS_EN adds the 'cont' request line.
`timescale 1ns/1ps
interface adc_sar_ctrl_if #(
    parameter int N = adc_sar_pkg::ADC_SAR_N
);
    logic         start;
    logic         busy;
    logic         done;
    logic [N-1:0] data;
    logic         ms_sample;
    logic         ms_clk;
    logic [N-1:0] ms_dac;
    logic         ms_cmp;
`ifdef ADC_SAR_CTRL_CONTINUOUS_EN
    logic         cont;
`endif

    modport master (
        output start,
        output ms_cmp,
`ifdef ADC_SAR_CTRL_CONTINUOUS_EN
        output cont,
`endif
        input  busy,
        input  done,
        input  data,
        input  ms_sample,
        input  ms_clk,
        input  ms_dac
    );

    modport slave (
        input  start,
        input  ms_cmp,
`ifdef ADC_SAR_CTRL_CONTINUOUS_EN
        input  cont,
`endif
        output busy,
        output done,
        output data,
        output ms_sample,
        output ms_clk,
        output ms_dac
    );
endinterface

// File: rtl/adc_sar_ctrl_chk.sv
// Simulation checker for the SAR controller: comparator output must be known when read.
`timescale 1ns/1ps
module adc_sar_ctrl_chk (
    input logic clk,
    input logic rst,
    input logic busy,
    input logic ms_sample,
    input logic ms_clk,
    input logic ms_cmp
);
    // busy with sample and comparator clock both low is exactly the LO read phase.
    a_cmp_known: assert property (@(posedge clk) disable iff (rst)
        (busy && !ms_sample && !ms_clk) |-> !$isunknown(ms_cmp))
        else $error("ms_cmp unknown in compare phase");
endmodule

// File: rtl/adc_sar_ctrl.sv
// Successive-approximation controller for the SAR ADC analog macro.
// Optional back-to-back conversions with ADC_SAR_CTRL_CONTINUOUS_EN.
`timescale 1ns/1ps
module adc_sar_ctrl
    import adc_sar_pkg::*;
#(
    parameter int N             = ADC_SAR_N,
    parameter int SAMPLE_CYCLES = ADC_SAR_SAMPLE_CYCLES
) (
    input logic           clk,
    input logic           rst,
    adc_sar_ctrl_if.slave bus
);
    localparam int CW = (SAMPLE_CYCLES > 1) ? $clog2(SAMPLE_CYCLES) : 1;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(SAMPLE_CYCLES - 1);
    localparam logic [IW-1:0] IDX_MSB  = IW'(N - 1);

    sar_state_t    state_r;
    sar_phase_t    phase_r;
    logic [CW-1:0] cnt_r;
    logic [IW-1:0] idx_r;
    logic [N-1:0]  sar_r;
    logic          busy_r;
    logic          done_r;
    logic [N-1:0]  data_r;
    logic          sample_r;
    logic          ms_clk_r;
    logic [N-1:0]  dac_r;
    logic          cmp_bit_s;
    logic [N-1:0]  sar_next_s;

    function automatic logic [N-1:0] bit_mask(input logic [IW-1:0] idx);
        return {{(N-1){1'b0}}, 1'b1} << idx;
    endfunction

    // Resolve the comparator bit (unknown reads as 0) and fold it into the result.
    always_comb begin
        cmp_bit_s  = 1'b0;
        sar_next_s = sar_r;
        if (bus.ms_cmp === 1'b1) begin
            cmp_bit_s = 1'b1;
        end else begin
            cmp_bit_s = 1'b0;
        end
        if (cmp_bit_s) begin
            sar_next_s = sar_r | bit_mask(idx_r);
        end else begin
            sar_next_s = sar_r;
        end
    end

    // Conversion sequencer: sample window, then two clk cycles per result bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            phase_r  <= PH_HI;
            cnt_r    <= {CW{1'b0}};
            idx_r    <= IDX_MSB;
            sar_r    <= {N{1'b0}};
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            data_r   <= {N{1'b0}};
            sample_r <= 1'b0;
            ms_clk_r <= 1'b0;
            dac_r    <= {N{1'b0}};
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (bus.start) begin
                        state_r  <= ST_SAMPLE;
                        cnt_r    <= CNT_LOAD;
                        sample_r <= 1'b1;
                        busy_r   <= 1'b1;
                    end
                end
                ST_SAMPLE: begin
                    if (cnt_r == {CW{1'b0}}) begin
                        sample_r <= 1'b0;
                        dac_r    <= {1'b1, {(N-1){1'b0}}};
                        ms_clk_r <= 1'b1;
                        idx_r    <= IDX_MSB;
                        sar_r    <= {N{1'b0}};
                        phase_r  <= PH_HI;
                        state_r  <= ST_CONV;
                    end else begin
                        cnt_r <= cnt_r - CW'(1);
                    end
                end
                ST_CONV: begin
                    case (phase_r)
                        PH_HI: begin
                            ms_clk_r <= 1'b0;
                            phase_r  <= PH_LO;
                        end
                        PH_LO: begin
                            if (idx_r != {IW{1'b0}}) begin
                                sar_r    <= sar_next_s;
                                dac_r    <= sar_next_s | bit_mask(idx_r - IW'(1));
                                ms_clk_r <= 1'b1;
                                idx_r    <= idx_r - IW'(1);
                                phase_r  <= PH_HI;
                            end else begin
                                sar_r   <= sar_next_s;
                                data_r  <= sar_next_s;
                                done_r  <= 1'b1;
                                dac_r   <= {N{1'b0}};
                                phase_r <= PH_HI;
                                idx_r   <= IDX_MSB;
`ifdef ADC_SAR_CTRL_CONTINUOUS_EN
                                if (bus.cont) begin
                                    state_r  <= ST_SAMPLE;
                                    cnt_r    <= CNT_LOAD;
                                    sample_r <= 1'b1;
                                end else begin
                                    state_r <= ST_IDLE;
                                    busy_r  <= 1'b0;
                                end
`else
                                state_r <= ST_IDLE;
                                busy_r  <= 1'b0;
`endif
                            end
                        end
                        default: phase_r <= PH_HI;
                    endcase
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.data      = data_r;
    assign bus.ms_sample = sample_r;
    assign bus.ms_clk    = ms_clk_r;
    assign bus.ms_dac    = dac_r;
endmodule

// File: tb/tb_adc_sar_ctrl.sv
// Directed self-checking bench for adc_sar_ctrl with a behavioural SAR analog model.
`timescale 1ns/1ps
module tb_adc_sar_ctrl;
    localparam int N  = 12;
    localparam int SC = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic cmp_m = 1'b0;

    adc_sar_ctrl_if #(.N(N)) bus ();

    adc_sar_ctrl #(.N(N), .SAMPLE_CYCLES(SC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    adc_sar_ctrl_chk chk (
        .clk       (clk),
        .rst       (rst),
        .busy      (bus.busy),
        .ms_sample (bus.ms_sample),
        .ms_clk    (bus.ms_clk),
        .ms_cmp    (bus.ms_cmp)
    );

    always #5 clk = ~clk;

    assign bus.ms_cmp = cmp_m;

    // Analog model: VREF=1.0 V, hold on falling ms_sample, strict compare on falling ms_clk.
    real vin    = 0.0;
    real held_v = 0.0;
    int  trials[$];

    always @(negedge bus.ms_sample) held_v = vin;

    always @(negedge bus.ms_clk) begin
        trials.push_back(int'(bus.ms_dac));
        cmp_m = (held_v > (real'(bus.ms_dac) / 4096.0)) ? 1'b1 : 1'b0;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic start_conv(input real v);
        vin = v;
        trials.delete();
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input int max_cyc, output int cyc, output int hi);
        cyc = 0;
        hi  = 0;
        while (cyc < max_cyc) begin
            @(posedge clk);
            #1;
            cyc++;
            if (bus.ms_sample) hi++;
            if (bus.done) break;
        end
        check_eq("done_seen", int'(bus.done), 1);
    endtask

    task automatic run_conv(input real v, input int exp, input string tag);
        int cyc, hi, hi0;
        start_conv(v);
        hi0 = bus.ms_sample ? 1 : 0;
        check_eq({tag, "_busy_acc"}, int'(bus.busy), 1);
        wait_done(60, cyc, hi);
        check_eq({tag, "_latency"}, cyc, SC + 2 * N);
        check_eq({tag, "_data"}, int'(bus.data), exp);
        check_eq({tag, "_sample_w"}, hi + hi0, SC);
        check_eq({tag, "_busy_end"}, int'(bus.busy), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int cyc, hi, dones, dval;
        bus.start = 1'b0;
`ifdef ADC_SAR_CTRL_CONTINUOUS_EN
        bus.cont = 1'b0;
`endif
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_busy", int'(bus.busy), 0);
        check_eq("rst_done", int'(bus.done), 0);
        check_eq("rst_data", int'(bus.data), 0);
        check_eq("rst_sample", int'(bus.ms_sample), 0);
        check_eq("rst_msclk", int'(bus.ms_clk), 0);
        check_eq("rst_dac", int'(bus.ms_dac), 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        run_conv(0.3, 1228, "v03");
        check_eq("v03_ntrials", trials.size(), N);
        if (trials.size() >= 2) begin
            check_eq("v03_trial0", trials[0], 2048);
            check_eq("v03_trial1", trials[1], 1024);
        end
        check_eq("v03_dac_idle", int'(bus.ms_dac), 0);
        repeat (3) @(posedge clk);
        #1;
        check_eq("v03_data_hold", int'(bus.data), 1228);
        check_eq("v03_done_pulse", int'(bus.done), 0);

        run_conv(0.5, 2047, "v05");
        run_conv(0.0, 0, "v00");
        run_conv(1.0, 4095, "v10");

        // Second start while busy must be ignored.
        start_conv(0.3);
        dones = 0;
        dval  = 0;
        for (int c = 1; c <= 40; c++) begin
            if (c == 10) begin
                vin = 0.8;
                bus.start = 1'b1;
            end else begin
                bus.start = 1'b0;
            end
            @(posedge clk);
            #1;
            if (bus.done) begin
                dones++;
                dval = int'(bus.data);
            end
        end
        check_eq("ign_done_cnt", dones, 1);
        check_eq("ign_data", dval, 1228);

        // Asynchronous reset in the middle of a conversion.
        start_conv(0.3);
        repeat (14) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check_eq("mid_rst_busy", int'(bus.busy), 0);
        check_eq("mid_rst_done", int'(bus.done), 0);
        check_eq("mid_rst_data", int'(bus.data), 0);
        check_eq("mid_rst_sample", int'(bus.ms_sample), 0);
        check_eq("mid_rst_msclk", int'(bus.ms_clk), 0);
        check_eq("mid_rst_dac", int'(bus.ms_dac), 0);
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;
        run_conv(0.3, 1228, "after_rst");

        // start held high: back-to-back with one IDLE cycle between conversions.
        vin = 0.1;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        wait_done(60, cyc, hi);
        check_eq("held1_data", int'(bus.data), 409);
        vin = 0.2;
        wait_done(60, cyc, hi);
        check_eq("held2_gap", cyc, SC + 2 * N + 1);
        check_eq("held2_data", int'(bus.data), 819);
        check_eq("held2_sample_w", hi, SC);
        vin = 0.3;
        wait_done(60, cyc, hi);
        bus.start = 1'b0;
        check_eq("held3_gap", cyc, SC + 2 * N + 1);
        check_eq("held3_data", int'(bus.data), 1228);
        check_eq("held3_sample_w", hi, SC);
        @(posedge clk);
        #1;
        check_eq("held_stop_busy", int'(bus.busy), 0);

`ifdef ADC_SAR_CTRL_CONTINUOUS_EN
        bus.cont = 1'b1;
        start_conv(0.1);
        wait_done(60, cyc, hi);
        check_eq("cont1_data", int'(bus.data), 409);
        check_eq("cont1_busy", int'(bus.busy), 1);
        vin = 0.2;
        wait_done(60, cyc, hi);
        check_eq("cont2_gap", cyc, SC + 2 * N);
        check_eq("cont2_data", int'(bus.data), 819);
        check_eq("cont2_busy", int'(bus.busy), 1);
        vin = 0.3;
        repeat (10) @(posedge clk);
        #1;
        bus.cont = 1'b0;
        wait_done(60, cyc, hi);
        check_eq("cont3_rest", cyc, SC + 2 * N - 10);
        check_eq("cont3_data", int'(bus.data), 1228);
        check_eq("cont3_busy", int'(bus.busy), 0);
        @(posedge clk);
        #1;
        check_eq("cont_stop_busy", int'(bus.busy), 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
